// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle RISC-V controller.
//   state_t  : FSM state encoding (4 bits)
//   OP_*     : RV32I major opcodes recognised by the controller
//   IMM_*, RES_*, SRCA_*, SRCB_*, ALUOP_* : datapath select encodings
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALRADR  = 4'd12,
    S_JALR     = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_U     = 2'b11;

endpackage

// File: rtl/mc_imm_decode.sv
// Immediate-format decoder: maps the major opcode to the ImmSrc select
// used by the external immediate extender.
//   op     in  7  IR[6:0]
//   ImmSrc out 3  immediate format select
module mc_imm_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] ImmSrc
);

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: ImmSrc = IMM_I;
      OP_STORE:                 ImmSrc = IMM_S;
      OP_BRANCH:                ImmSrc = IMM_B;
      OP_JAL:                   ImmSrc = IMM_J;
      OP_LUI:                   ImmSrc = IMM_U;
      default:                  ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle RISC-V datapath through
// fetch / decode / execute / memory / writeback, stalling on mem_ready.
//   clk, rst      : clock, synchronous active-high reset
//   op            : IR[6:0]
//   branch_taken  : external branch comparator result
//   mem_ready     : memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUOp, ImmSrc, RegWrite : datapath enables and selects
//   retire        : pulse in the final state of each instruction
//   illegal_op    : pulse on an unsupported opcode
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       retire,
  output logic       illegal_op
);

  state_t state;
  state_t next_state;

  mc_imm_decode u_imm_decode (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_IMM:            next_state = S_EXECI;
          OP_LUI:            next_state = S_LUI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALRADR;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_LUI:      next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_JALRADR:  next_state = S_JALR;
      S_JALR:     next_state = S_ALUWB;
      S_ILLEGAL:  next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // Reset is checked before the state decode so an instruction caught
  // mid-flight issues no write on the reset edge, whatever its state.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALUOP_ADD;
    RegWrite   = 1'b0;
    retire     = 1'b0;
    illegal_op = 1'b0;
    if (rst) begin
      ResultSrc = RES_ALU;
      ALUSrcB   = SRCB_FOUR;
    end else begin
      case (state)
        S_FETCH: begin
          ResultSrc = RES_ALU;
          ALUSrcB   = SRCB_FOUR;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
          retire    = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          retire   = mem_ready;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
        end
        S_LUI: begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_U;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_BR;
          PCWrite = branch_taken;
          retire  = 1'b1;
        end
        // PC takes the target left in ALUOut while the ALU forms OldPC+4
        // for the link register.
        S_JAL, S_JALR: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        S_JALRADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        S_ILLEGAL: illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the full output vector against hand-built
// per-state expectations.
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [15:0] obs;
  logic [15:0] e;

  int total = 0;
  int bad   = 0;

  multicycle_controller dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .ImmSrc       (ImmSrc),
    .RegWrite     (RegWrite),
    .retire       (retire),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
  //  RegWrite, retire, illegal_op}
  always_comb obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                     ALUSrcB, ALUOp, RegWrite, retire, illegal_op};

  function automatic logic [15:0] expv(input state_t st, input logic mr, input logic bt);
    case (st)
      S_FETCH:    return {mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};
      S_DECODE:   return {4'b0000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000};
      S_MEMADR:   return {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000};
      S_MEMREAD:  return {4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
      S_MEMWB:    return {4'b0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b110};
      S_MEMWRITE: return {4'b0110, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, mr, 1'b0};
      S_EXECR:    return {4'b0000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000};
      S_EXECI:    return {4'b0000, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000};
      S_LUI:      return {4'b0000, 2'b00, 2'b00, 2'b01, 2'b11, 3'b000};
      S_ALUWB:    return {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b110};
      S_BRANCH:   return {bt, 3'b000, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010};
      S_JAL:      return {4'b1000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000};
      S_JALR:     return {4'b1000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000};
      S_JALRADR:  return {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000};
      S_ILLEGAL:  return {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001};
      default:    return 16'hffff;
    endcase
  endfunction

  // One clock: apply inputs, check outputs at the falling edge, then
  // advance past the rising edge.
  task automatic step(input string tag, input state_t st, input logic mr,
                      input logic bt, input logic r);
    mem_ready    = mr;
    branch_taken = bt;
    rst          = r;
    // During reset: FETCH selects, every enable low.
    e = r ? {4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000} : expv(st, mr, bt);
    @(negedge clk);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_imm(input string tag, input logic [2:0] exp_imm);
    #1;
    total++;
    assert (ImmSrc === exp_imm) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, ImmSrc, exp_imm);
    end
  endtask

  initial begin
    // reset with mem_ready high: fetch enables must stay low
    step("rst0", S_FETCH, 1'b1, 1'b0, 1'b1);
    step("rst1", S_FETCH, 1'b1, 1'b0, 1'b1);

    // add; op scrambled after DECODE must not matter
    op = 7'b0110011;
    step("add_fetch",  S_FETCH,  1'b1, 1'b0, 1'b0);
    step("add_decode", S_DECODE, 1'b1, 1'b0, 1'b0);
    op = 7'b1111111;
    step("add_execr",  S_EXECR,  1'b1, 1'b0, 1'b0);
    step("add_aluwb",  S_ALUWB,  1'b1, 1'b0, 1'b0);

    // addi with one fetch stall cycle
    op = 7'b0010011;
    chk_imm("addi_imm", 3'b000);
    step("addi_fstall", S_FETCH,  1'b0, 1'b0, 1'b0);
    step("addi_fetch",  S_FETCH,  1'b1, 1'b0, 1'b0);
    step("addi_decode", S_DECODE, 1'b0, 1'b0, 1'b0);
    step("addi_execi",  S_EXECI,  1'b1, 1'b0, 1'b0);
    step("addi_aluwb",  S_ALUWB,  1'b1, 1'b0, 1'b0);

    // lui
    op = 7'b0110111;
    chk_imm("lui_imm", 3'b100);
    step("lui_fetch",  S_FETCH,  1'b1, 1'b0, 1'b0);
    step("lui_decode", S_DECODE, 1'b1, 1'b0, 1'b0);
    step("lui_exec",   S_LUI,    1'b1, 1'b0, 1'b0);
    step("lui_aluwb",  S_ALUWB,  1'b1, 1'b0, 1'b0);

    // lw with two wait cycles in MEMREAD: 7 cycles
    op = 7'b0000011;
    chk_imm("lw_imm", 3'b000);
    step("lw_fetch",  S_FETCH,   1'b1, 1'b0, 1'b0);
    step("lw_decode", S_DECODE,  1'b1, 1'b0, 1'b0);
    step("lw_memadr", S_MEMADR,  1'b1, 1'b0, 1'b0);
    step("lw_rd_w0",  S_MEMREAD, 1'b0, 1'b0, 1'b0);
    step("lw_rd_w1",  S_MEMREAD, 1'b0, 1'b0, 1'b0);
    step("lw_rd",     S_MEMREAD, 1'b1, 1'b0, 1'b0);
    step("lw_memwb",  S_MEMWB,   1'b1, 1'b0, 1'b0);

    // sw with one wait cycle
    op = 7'b0100011;
    chk_imm("sw_imm", 3'b001);
    step("sw_fetch",  S_FETCH,    1'b1, 1'b0, 1'b0);
    step("sw_decode", S_DECODE,   1'b1, 1'b0, 1'b0);
    step("sw_memadr", S_MEMADR,   1'b1, 1'b0, 1'b0);
    step("sw_wr_w0",  S_MEMWRITE, 1'b0, 1'b0, 1'b0);
    step("sw_wr",     S_MEMWRITE, 1'b1, 1'b0, 1'b0);

    // beq not taken, then taken
    op = 7'b1100011;
    chk_imm("beq_imm", 3'b010);
    step("beq0_fetch",  S_FETCH,  1'b1, 1'b0, 1'b0);
    step("beq0_decode", S_DECODE, 1'b1, 1'b0, 1'b0);
    step("beq0_branch", S_BRANCH, 1'b1, 1'b0, 1'b0);
    step("beq1_fetch",  S_FETCH,  1'b1, 1'b1, 1'b0);
    step("beq1_decode", S_DECODE, 1'b1, 1'b1, 1'b0);
    step("beq1_branch", S_BRANCH, 1'b1, 1'b1, 1'b0);

    // jal
    op = 7'b1101111;
    chk_imm("jal_imm", 3'b011);
    step("jal_fetch",  S_FETCH,  1'b1, 1'b0, 1'b0);
    step("jal_decode", S_DECODE, 1'b1, 1'b0, 1'b0);
    step("jal_jal",    S_JAL,    1'b1, 1'b0, 1'b0);
    step("jal_aluwb",  S_ALUWB,  1'b1, 1'b0, 1'b0);

    // jalr: 5 cycles
    op = 7'b1100111;
    chk_imm("jalr_imm", 3'b000);
    step("jalr_fetch",  S_FETCH,   1'b1, 1'b0, 1'b0);
    step("jalr_decode", S_DECODE,  1'b1, 1'b0, 1'b0);
    step("jalr_adr",    S_JALRADR, 1'b1, 1'b0, 1'b0);
    step("jalr_jalr",   S_JALR,    1'b1, 1'b0, 1'b0);
    step("jalr_aluwb",  S_ALUWB,   1'b1, 1'b0, 1'b0);

    // unsupported opcode
    op = 7'b1111111;
    chk_imm("ill_imm", 3'b000);
    step("ill_fetch",   S_FETCH,   1'b1, 1'b0, 1'b0);
    step("ill_decode",  S_DECODE,  1'b1, 1'b0, 1'b0);
    step("ill_illegal", S_ILLEGAL, 1'b1, 1'b0, 1'b0);
    step("ill_refetch", S_FETCH,   1'b0, 1'b0, 1'b0);

    // sw abandoned by reset while stalled in MEMWRITE
    op = 7'b0100011;
    step("swr_fetch",  S_FETCH,  1'b1, 1'b0, 1'b0);
    step("swr_decode", S_DECODE, 1'b1, 1'b0, 1'b0);
    step("swr_memadr", S_MEMADR, 1'b1, 1'b0, 1'b0);
    step("swr_rst",    S_MEMWRITE, 1'b0, 1'b0, 1'b1);
    step("swr_after",  S_FETCH,  1'b0, 1'b0, 1'b0);

    // add abandoned by reset in ALUWB: no RegWrite on that edge
    op = 7'b0110011;
    step("addr_fetch",  S_FETCH,  1'b1, 1'b0, 1'b0);
    step("addr_decode", S_DECODE, 1'b1, 1'b0, 1'b0);
    step("addr_execr",  S_EXECR,  1'b1, 1'b0, 1'b0);
    step("addr_rst",    S_ALUWB,  1'b1, 1'b0, 1'b1);
    step("addr_after",  S_FETCH,  1'b1, 1'b0, 1'b0);
    step("addr_decode2", S_DECODE, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
